// File: rtl/axi4_burst_sram.sv
// ---------------------------------------------------------------------------
// axi4_burst_sram
//
// AXI4 slave wrapping a MEM_WORDS x 32-bit single-port synchronous RAM.
// Serves FIXED / INCR / WRAP bursts of 32-bit beats, one transaction at a
// time. Write and read bursts share the RAM port, so no interleaving exists.
//
// Every beat is range checked against the byte window 0 .. MEM_WORDS*4-1:
//   - An out-of-range write beat is dropped and makes the write burst SLVERR.
//   - An out-of-range read beat returns zero data with SLVERR for that beat.
// An unsupported WRAP length or burst type 11 makes the whole burst SLVERR.
// That burst then walks addresses as INCR.
//
// INIT_FILE is accepted so that instantiations carrying an image name still
// elaborate. The block never loads it, so RAM contents start undefined.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_aw*              write address channel (id, addr, len, burst)
//   s_axi_w*               write data channel (data, strobes, last)
//   s_axi_b*               write response channel (id, resp)
//   s_axi_ar*              read address channel (id, addr, len, burst)
//   s_axi_r*               read data channel (id, data, resp, last)
// ---------------------------------------------------------------------------
module axi4_burst_sram #(
    parameter int    MEM_WORDS = 1024,
    parameter int    ID_WIDTH  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                aclk,
    input  logic                aresetn,
    // write address
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    // write data
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int          IDXW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic PRIO_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        W_BEAT,
        W_RESP,
        R_BEAT
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q;
    logic                prio_q;        // which side wins a simultaneous request
    logic [31:0]         addr_q;        // word-aligned address of the current beat
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;         // beat index of the next write / read fetch
    logic [1:0]          burst_q;
    logic                err_q;         // sticky write-burst error
    logic                wready_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [ID_WIDTH-1:0] bid_q;
    logic [ID_WIDTH-1:0] rid_q;
    logic                rvalid_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;
    logic                rzero_q;       // presented beat was out of range
    logic                fetch_done_q;  // final read beat already fetched

    logic [31:0]         mem [MEM_WORDS];
    logic [31:0]         ram_rd_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic            aw_hs;
    logic            ar_hs;
    logic [IDXW-1:0] idx;
    logic            oor;
    logic            wrap_ok;
    logic            bad_burst;
    logic            last_beat;
    logic [31:0]     addr_d;
    logic            w_hs;
    logic            r_hs;
    logic            r_ld;
    logic            mem_we;
    logic            mem_re;
    logic            err_d;

    // The offset mask of a WRAP window is (len+1)*4-1. For the legal lengths
    // 1/3/7/15 that value is simply {len, 2'b11}.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [7:0]  len,
                                              input logic [1:0]  bt,
                                              input logic        wok);
        logic [31:0] mask;
        logic [31:0] res;
        mask = {22'd0, len, 2'b11};
        if (bt == BURST_FIXED) begin
            res = a;
        end else if (bt == BURST_WRAP && wok) begin
            res = (a & ~mask) | ((a + 32'd4) & mask);
        end else begin
            res = a + 32'd4;
        end
        return res;
    endfunction

    assign aw_hs = (state_q == IDLE) && s_axi_awvalid &&
                   (!s_axi_arvalid || prio_q == PRIO_WRITE);
    assign ar_hs = (state_q == IDLE) && s_axi_arvalid &&
                   (!s_axi_awvalid || prio_q != PRIO_WRITE);

    always_comb begin
        idx       = addr_q[IDXW+1:2];
        oor       = (addr_q >= MEM_BYTES);
        wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) ||
                    (len_q == 8'd7) || (len_q == 8'd15);
        bad_burst = (burst_q == BURST_RSVD) || (burst_q == BURST_WRAP && !wrap_ok);
        last_beat = (cnt_q == len_q);
        addr_d    = next_addr(addr_q, len_q, burst_q, wrap_ok);
        w_hs      = s_axi_wvalid && wready_q;
        r_hs      = rvalid_q && s_axi_rready;
        // Fetch the next read beat whenever the output register is empty or
        // is being drained this cycle. This streams one beat per cycle and
        // holds the presented beat while the master stalls.
        r_ld      = (state_q == R_BEAT) && !fetch_done_q && (!rvalid_q || s_axi_rready);
        mem_we    = w_hs && !oor;
        mem_re    = r_ld && !oor;
        err_d     = err_q || oor || bad_burst || (s_axi_wlast != last_beat);
    end

    // -----------------------------------------------------------------------
    // RAM: byte-enabled write, registered read held while not enabled
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem[idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        if (mem_re) ram_rd_q <= mem[idx];
    end

    // -----------------------------------------------------------------------
    // Transaction FSM with registered channel outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            prio_q       <= PRIO_WRITE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            bid_q        <= '0;
            rid_q        <= '0;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rlast_q      <= 1'b0;
            rzero_q      <= 1'b1;
            fetch_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        bid_q    <= s_axi_awid;
                        addr_q   <= s_axi_awaddr & 32'hFFFF_FFFC;
                        len_q    <= s_axi_awlen;
                        burst_q  <= s_axi_awburst;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        wready_q <= 1'b1;
                        prio_q   <= ~prio_q;
                        state_q  <= W_BEAT;
                    end else if (ar_hs) begin
                        rid_q        <= s_axi_arid;
                        addr_q       <= s_axi_araddr & 32'hFFFF_FFFC;
                        len_q        <= s_axi_arlen;
                        burst_q      <= s_axi_arburst;
                        cnt_q        <= '0;
                        fetch_done_q <= 1'b0;
                        prio_q       <= ~prio_q;
                        state_q      <= R_BEAT;
                    end
                end

                W_BEAT: begin
                    if (w_hs) begin
                        err_q  <= err_d;
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 8'd1;
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= W_RESP;
                        end
                    end
                end

                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                R_BEAT: begin
                    if (r_ld) begin
                        rvalid_q <= 1'b1;
                        rzero_q  <= oor;
                        rresp_q  <= (oor || bad_burst) ? RESP_SLVERR : RESP_OKAY;
                        rlast_q  <= last_beat;
                        addr_q   <= addr_d;
                        cnt_q    <= cnt_q + 8'd1;
                        if (last_beat) fetch_done_q <= 1'b1;
                    end else if (r_hs && rlast_q) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi_awready = aw_hs;
    assign s_axi_arready = ar_hs;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    // Out-of-range beats (and the post-reset state) present zero data.
    assign s_axi_rdata   = rzero_q ? 32'd0 : ram_rd_q;

endmodule

// File: tb/tb_axi4_burst_sram.sv
module tb_axi4_burst_sram;
    localparam int          MW = 256;
    localparam logic [31:0] MB = 32'(MW * 4);

    logic        aclk, aresetn;
    logic [3:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic [3:0]  s_axi_wstrb;
    logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic s_axi_rlast, s_axi_rvalid, s_axi_rready;

    axi4_burst_sram #(.MEM_WORDS(MW), .ID_WIDTH(4), .INIT_FILE("")) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_err = 0;

    logic [49:0] outs;
    assign outs = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                   s_axi_bid, s_axi_rvalid, s_axi_rresp, s_axi_rlast, s_axi_rid, s_axi_rdata};

    // Reference memory: word contents plus per-byte "has been written" flags.
    logic [31:0] mdl [MW];
    logic [3:0]  kb  [MW];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit wrap_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic bit bad_burst(input logic [7:0] len, input logic [1:0] bt);
        return bt == 2'b11 || (bt == 2'b10 && !wrap_ok(len));
    endfunction

    // Byte address of beat i, straight from the burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] bt, input int i);
        logic [31:0] a0, size, base;
        a0 = a & 32'hFFFF_FFFC;
        if (bt == 2'b00) return a0;
        if (bt == 2'b10 && wrap_ok(len)) begin
            size = (32'(len) + 32'd1) * 32'd4;
            base = a0 - (a0 % size);
            return base + ((a0 - base + 32'(4 * i)) % size);
        end
        return a0 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt);
        logic hs = 1'b0;
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awburst = bt;
        s_axi_awvalid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_awready;
            @(posedge aclk); #1; n++;
        end
        if (!hs) chk("aw_timeout", {63'd0, hs}, 64'd1);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt);
        logic hs = 1'b0;
        int n = 0;
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arburst = bt;
        s_axi_arvalid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_arready;
            @(posedge aclk); #1; n++;
        end
        if (!hs) chk("ar_timeout", {63'd0, hs}, 64'd1);
        s_axi_arvalid = 1'b0;
    endtask

    // W beats from wdat/wstb, wlast on beat wl, then the B response.
    task automatic do_w(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [1:0] bt, input int wl, input bit gaps);
        logic err, hs;
        logic [31:0] ba;
        int n, w, stall;
        err = bad_burst(len, bt);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_axi_wvalid = 1'b0;
                @(posedge aclk); #1;
            end
            s_axi_wvalid = 1'b1; s_axi_wdata = wdat[i]; s_axi_wstrb = wstb[i];
            s_axi_wlast = (i == wl);
            hs = 1'b0; n = 0;
            while (!hs && n < 100) begin
                @(negedge aclk); hs = s_axi_wready;
                @(posedge aclk); #1; n++;
            end
            if (!hs) chk("w_timeout", {63'd0, hs}, 64'd1);
            ba = beat_addr(a, len, bt, i);
            if ((i == wl) != (i == int'(len))) err = 1'b1;
            if (ba >= MB) err = 1'b1;
            else begin
                w = int'(ba[9:2]);
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) begin
                        mdl[w][8*b +: 8] = wdat[i][8*b +: 8];
                        kb[w][b] = 1'b1;
                    end
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        @(negedge aclk); chk("b_first", {63'd0, s_axi_bvalid}, 64'd1);
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) begin
            @(posedge aclk); #1;
            @(negedge aclk); chk("b_hold", {63'd0, s_axi_bvalid}, 64'd1);
        end
        @(posedge aclk); #1; s_axi_bready = 1'b1;
        @(negedge aclk);
        chk("bvalid", {63'd0, s_axi_bvalid}, 64'd1);
        chk("bid", {60'd0, s_axi_bid}, {60'd0, id});
        chk("bresp", {62'd0, s_axi_bresp}, err ? 64'd2 : 64'd0);
        @(posedge aclk); #1; s_axi_bready = 1'b0;
    endtask

    // R beats; called right after the AR handshake edge. mode: 0 rready
    // high, 1 random, 2 pattern 1-0-0-1.
    task automatic do_r(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [1:0] bt, input int mode);
        int beat = 0, cyc = 0, w;
        logic have_prev = 1'b0;
        logic [63:0] prev, cur;
        logic [31:0] ba, m;
        while (beat <= int'(len) && cyc < 600) begin
            case (mode)
                0: s_axi_rready = 1'b1;
                1: s_axi_rready = 1'($urandom_range(1));
                default: s_axi_rready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(negedge aclk);
            if (cyc == 0) chk("r_lat1", {63'd0, s_axi_rvalid}, 64'd0);
            if (cyc == 1) chk("r_lat2", {63'd0, s_axi_rvalid}, 64'd1);
            cur = {25'd0, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata};
            if (s_axi_rvalid) begin
                if (have_prev) chk("r_stable", cur, prev);
                if (s_axi_rready) begin
                    ba = beat_addr(a, len, bt, beat);
                    chk("rid", {60'd0, s_axi_rid}, {60'd0, id});
                    chk("rlast", {63'd0, s_axi_rlast}, {63'd0, beat == int'(len)});
                    chk("rresp", {62'd0, s_axi_rresp},
                        (ba >= MB || bad_burst(len, bt)) ? 64'd2 : 64'd0);
                    if (ba >= MB) chk("rdata_oor", {32'd0, s_axi_rdata}, 64'd0);
                    else begin
                        w = int'(ba[9:2]);
                        m = bmask(kb[w]);
                        if (m != 0) chk("rdata", {32'd0, s_axi_rdata & m}, {32'd0, mdl[w] & m});
                    end
                    beat++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev = cur;
                end
            end
            @(posedge aclk); #1; cyc++;
        end
        s_axi_rready = 1'b0;
        if (beat <= int'(len)) chk("r_timeout", 64'(beat), 64'(len) + 64'd1);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] bt, input int wl, input bit gaps);
        do_aw(id, a, len, bt);
        do_w(id, a, len, bt, wl, gaps);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] bt, input int mode);
        do_ar(id, a, len, bt);
        do_r(id, a, len, bt, mode);
        @(negedge aclk); chk("r_idle", {63'd0, s_axi_rvalid}, 64'd0);
        @(posedge aclk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  bt;
        logic        g;
        int          n, wl;
        for (int i = 0; i < MW; i++) begin mdl[i] = '0; kb[i] = '0; end
        aresetn = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1 chk("rst_outs", {14'd0, outs}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk); chk("rst_release", {14'd0, outs}, 64'd0);
        @(posedge aclk); #1;

        // single write / read
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        wr(4'd1, 32'h10, 8'd0, 2'b01, 0, 0);
        rd(4'd2, 32'h10, 8'd0, 2'b01, 0);

        // INCR with partial strobe on beat 2
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        wr(4'd3, 32'h104, 8'd0, 2'b01, 0, 0);
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        wstb[1] = 4'b0011;
        wr(4'd4, 32'h100, 8'd3, 2'b01, 3, 0);
        rd(4'd5, 32'h100, 8'd3, 2'b01, 0);

        // WRAP read
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
        for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
        wr(4'd6, 32'h200, 8'd3, 2'b01, 3, 0);
        rd(4'd7, 32'h208, 8'd3, 2'b10, 0);

        // error cases: early wlast, out-of-range write, bad WRAP length, burst 11
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr(4'd8, 32'h300, 8'd3, 2'b01, 1, 0);
        wr(4'd9, MB, 8'd0, 2'b01, 0, 0);
        wr(4'd10, 32'h340, 8'd2, 2'b10, 2, 0);
        rd(4'd11, 32'h340, 8'd2, 2'b11, 0);

        // top-of-window read
        wdat[0] = $urandom; wstb[0] = 4'hF;
        wr(4'd12, MB - 4, 8'd0, 2'b01, 0, 0);
        rd(4'd13, MB - 4, 8'd1, 2'b01, 0);

        // stalled len=7 read
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr(4'd14, 32'h180, 8'd7, 2'b01, 7, 0);
        rd(4'd15, 32'h180, 8'd7, 2'b01, 2);

        // reset in the middle of a read burst
        do_ar(4'd3, 32'h180, 8'd7, 2'b01);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b0;
        #1 chk("rst_mid", {14'd0, outs}, 64'd0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk); chk("rst_mid_release", {14'd0, outs}, 64'd0);
        @(posedge aclk); #1;

        // simultaneous AW/AR after reset: W, R, W, R
        wdat[0] = $urandom; wstb[0] = 4'hF;
        s_axi_awid = 4'd1; s_axi_awaddr = 32'h40; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
        s_axi_arid = 4'd2; s_axi_araddr = 32'h10; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            g = 1'b0; n = 0;
            while (!(s_axi_awready || s_axi_arready) && n < 100) begin
                @(negedge aclk);
                if (!(s_axi_awready || s_axi_arready)) begin @(posedge aclk); #1; end
                n++;
            end
            chk("arb_aw", {63'd0, s_axi_awready}, {63'd0, r % 2 == 0});
            chk("arb_ar", {63'd0, s_axi_arready}, {63'd0, r % 2 == 1});
            g = s_axi_awready;
            @(posedge aclk); #1;
            if (g) begin
                s_axi_awvalid = 1'b0; s_axi_awvalid = 1'b1;
                do_w(4'd1, 32'h40, 8'd0, 2'b01, 0, 0);
            end else begin
                do_r(4'd2, 32'h10, 8'd0, 2'b01, 0);
            end
        end
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(posedge aclk); #1;

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            a   = ($urandom_range(0, MW + 8) * 4) | 32'($urandom_range(0, 3));
            len = 8'($urandom_range(0, 15));
            bt  = 2'($urandom_range(0, 3));
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom_range(1, 15));
                end
                wl = ($urandom_range(7) == 0) ? int'($urandom_range(0, 15)) : int'(len);
                wr(4'($urandom), a, len, bt, wl, 1);
            end else begin
                rd(4'($urandom), a, len, bt, int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
